multicycle_control: RTL and testbench

- Control sequencer that runs the RISC-V datapath in multicycle mode: FETCH, DECODE, EXEC, MEM, WB.
- Drives the per-cycle enables and mux selects of a datapath that shares one memory for instructions and data.
- Supports memory wait states through a ready handshake, counts retired instructions, and halts on illegal opcodes, ECALL or a memory timeout.
- Replaces the single-cycle Control block; ALUControl still decodes funct fields when alu_op=10.

---
 rtl/multicycle_control.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared
// instruction/data memory, with ready-based wait states, retire counting and halt.
module multicycle_control #(
  parameter int INSTRET_W = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 pc_source,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 illegal,
  output logic                 mem_timeout,
  output logic [INSTRET_W-1:0] instret
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t               state_r;
  state_t               state_n;
  logic [CNT_W-1:0]     wait_cnt_r;
  logic                 illegal_r;
  logic                 mem_timeout_r;
  logic [INSTRET_W-1:0] instret_r;

  logic pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s;
  logic retire_s, waiting_s, set_illegal_s, set_timeout_s;

  // Next-state and output decode from the current state and instruction fields
  always_comb begin
    state_n       = state_r;
    pc_write_s    = 1'b0;
    ir_write_s    = 1'b0;
    mem_read_s    = 1'b0;
    mem_write_s   = 1'b0;
    reg_write_s   = 1'b0;
    i_or_d        = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 1'b0;
    retire_s      = 1'b0;
    waiting_s     = 1'b0;
    set_illegal_s = 1'b0;
    set_timeout_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
        if (mem_ready) begin
          state_n = S_DECODE;
        end else begin
          waiting_s = 1'b1;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ECALL: state_n = S_HALT;
          OP_R, OP_IMM, OP_LOAD, OP_STORE: state_n = S_EXEC;
          OP_BR: begin
            if (funct3[2:1] == 2'b00) begin
              state_n = S_EXEC;
            end else begin
              state_n       = S_HALT;
              set_illegal_s = 1'b1;
            end
          end
          default: begin
            state_n       = S_HALT;
            set_illegal_s = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        alu_src_a = 2'b10;
        case (opcode)
          OP_R: begin
            alu_op  = 2'b10;
            state_n = S_WB;
          end
          OP_IMM: begin
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            state_n   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_b = 2'b10;
            state_n   = S_MEM;
          end
          OP_BR: begin
            alu_op     = 2'b01;
            pc_source  = 1'b1;
            pc_write_s = funct3[0] ? ~zero : zero;
            retire_s   = 1'b1;
            state_n    = S_FETCH;
          end
          default: begin
            state_n       = S_HALT;
            set_illegal_s = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        case (opcode)
          OP_LOAD: begin
            mem_read_s = 1'b1;
            if (mem_ready) begin
              state_n = S_WB;
            end else begin
              waiting_s = 1'b1;
            end
          end
          OP_STORE: begin
            mem_write_s = 1'b1;
            if (mem_ready) begin
              state_n  = S_FETCH;
              retire_s = 1'b1;
            end else begin
              waiting_s = 1'b1;
            end
          end
          default: begin
            state_n       = S_HALT;
            set_illegal_s = 1'b1;
          end
        endcase
      end
      S_WB: begin
        reg_write_s = 1'b1;
        mem_to_reg  = (opcode == OP_LOAD);
        retire_s    = 1'b1;
        state_n     = S_FETCH;
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
    // Completion in the same cycle wins because waiting_s is only set without mem_ready
    if (waiting_s && (wait_cnt_r == CNT_W'(TIMEOUT - 1))) begin
      state_n       = S_HALT;
      set_timeout_s = 1'b1;
    end else begin
      set_timeout_s = 1'b0;
    end
  end

  // State, wait counter, sticky flags and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_FETCH;
      wait_cnt_r    <= '0;
      illegal_r     <= 1'b0;
      mem_timeout_r <= 1'b0;
      instret_r     <= '0;
    end else begin
      state_r       <= state_n;
      wait_cnt_r    <= (waiting_s && (state_n == state_r)) ? wait_cnt_r + CNT_W'(1'b1) : '0;
      illegal_r     <= illegal_r | set_illegal_s;
      mem_timeout_r <= mem_timeout_r | set_timeout_s;
      if (retire_s) begin
        instret_r <= instret_r + INSTRET_W'(1'b1);
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  assign pc_write    = pc_write_s & ~reset;
  assign ir_write    = ir_write_s & ~reset;
  assign mem_read    = mem_read_s & ~reset;
  assign mem_write   = mem_write_s & ~reset;
  assign reg_write   = reg_write_s & ~reset;
  assign state       = state_r;
  assign halted      = (state_r == S_HALT);
  assign illegal     = illegal_r;
  assign mem_timeout = mem_timeout_r;
  assign instret     = instret_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control (TIMEOUT=4) plus
// hand sequences for halt, timeout and reset-mid-instruction cases.
module tb_multicycle_control;

  localparam int R_OP = 'h33;
  localparam int I_OP = 'h13;
  localparam int LD   = 'h03;
  localparam int ST   = 'h23;
  localparam int BR   = 'h63;
  localparam int EC   = 'h73;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg;
  logic [1:0]  alu_src_a, alu_src_b, alu_op;
  logic        pc_source, halted, illegal, mem_timeout;
  logic [2:0]  state;
  logic [63:0] instret;

  always #5 clk = ~clk;

  multicycle_control #(.INSTRET_W(64), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .halted(halted), .illegal(illegal),
    .mem_timeout(mem_timeout), .instret(instret)
  );

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic [2:0]  st;
    logic [4:0]  stb;   // pc_write, ir_write, mem_read, mem_write, reg_write
    logic        iod;
    logic        m2r;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [1:0]  aop;
    logic        pcs;
    logic [63:0] ins;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input int rst, op, f3, z, rdy, st, stb, iod, m2r, a, b, aop, pcs, ins);
    vec_t v;
    v.rst = 1'(rst); v.op = 7'(op); v.f3 = 3'(f3); v.z = 1'(z); v.rdy = 1'(rdy);
    v.st = 3'(st); v.stb = 5'(stb); v.iod = 1'(iod); v.m2r = 1'(m2r);
    v.a = 2'(a); v.b = 2'(b); v.aop = 2'(aop); v.pcs = 1'(pcs); v.ins = 64'(ins);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int rst, op, f3, z, rdy);
    reset = 1'(rst); opcode = 7'(op); funct3 = 3'(f3); zero = 1'(z); mem_ready = 1'(rdy);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] ctl_act();
    return {state, pc_write, ir_write, mem_read, mem_write, reg_write, i_or_d, mem_to_reg,
            alu_src_a, alu_src_b, alu_op, pc_source, halted, illegal, mem_timeout};
  endfunction

  initial begin
    // rst op f3 z rdy | st stb iod m2r a b aop pcs instret
    add(1, R_OP, 0, 0, 1,  0, 5'b00000, 0, 0, 0, 1, 0, 0, 0);
    add(0, R_OP, 0, 0, 1,  0, 5'b11100, 0, 0, 0, 1, 0, 0, 0);
    add(0, R_OP, 0, 0, 1,  1, 5'b00000, 0, 0, 1, 2, 0, 0, 0);
    add(0, R_OP, 0, 0, 1,  2, 5'b00000, 0, 0, 2, 0, 2, 0, 0);
    add(0, R_OP, 0, 0, 1,  4, 5'b00001, 0, 0, 0, 0, 0, 0, 0);
    add(0, LD,   0, 0, 0,  0, 5'b00100, 0, 0, 0, 1, 0, 0, 1);
    add(0, LD,   0, 0, 1,  0, 5'b11100, 0, 0, 0, 1, 0, 0, 1);
    add(0, LD,   0, 0, 1,  1, 5'b00000, 0, 0, 1, 2, 0, 0, 1);
    add(0, LD,   0, 0, 1,  2, 5'b00000, 0, 0, 2, 2, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, LD, 0, 0, 0, 3, 5'b00100, 1, 0, 0, 0, 0, 0, 1);
    add(0, LD,   0, 0, 1,  3, 5'b00100, 1, 0, 0, 0, 0, 0, 1);
    add(0, LD,   0, 0, 1,  4, 5'b00001, 0, 1, 0, 0, 0, 0, 1);
    add(0, BR,   0, 1, 1,  0, 5'b11100, 0, 0, 0, 1, 0, 0, 2);
    add(0, BR,   0, 1, 1,  1, 5'b00000, 0, 0, 1, 2, 0, 0, 2);
    add(0, BR,   0, 1, 1,  2, 5'b10000, 0, 0, 2, 0, 1, 1, 2);
    add(0, BR,   0, 0, 1,  0, 5'b11100, 0, 0, 0, 1, 0, 0, 3);
    add(0, BR,   0, 0, 1,  1, 5'b00000, 0, 0, 1, 2, 0, 0, 3);
    add(0, BR,   0, 0, 1,  2, 5'b00000, 0, 0, 2, 0, 1, 1, 3);
    add(0, BR,   1, 1, 1,  0, 5'b11100, 0, 0, 0, 1, 0, 0, 4);
    add(0, BR,   1, 1, 1,  1, 5'b00000, 0, 0, 1, 2, 0, 0, 4);
    add(0, BR,   1, 1, 1,  2, 5'b00000, 0, 0, 2, 0, 1, 1, 4);
    add(0, BR,   1, 0, 1,  0, 5'b11100, 0, 0, 0, 1, 0, 0, 5);
    add(0, BR,   1, 0, 1,  1, 5'b00000, 0, 0, 1, 2, 0, 0, 5);
    add(0, BR,   1, 0, 1,  2, 5'b10000, 0, 0, 2, 0, 1, 1, 5);
    add(0, ST,   2, 0, 1,  0, 5'b11100, 0, 0, 0, 1, 0, 0, 6);
    add(0, ST,   2, 0, 1,  1, 5'b00000, 0, 0, 1, 2, 0, 0, 6);
    add(0, ST,   2, 0, 1,  2, 5'b00000, 0, 0, 2, 2, 0, 0, 6);
    add(0, ST,   2, 0, 0,  3, 5'b00010, 1, 0, 0, 0, 0, 0, 6);
    add(0, ST,   2, 0, 1,  3, 5'b00010, 1, 0, 0, 0, 0, 0, 6);
    add(0, I_OP, 0, 0, 1,  0, 5'b11100, 0, 0, 0, 1, 0, 0, 7);
    add(0, I_OP, 0, 0, 1,  1, 5'b00000, 0, 0, 1, 2, 0, 0, 7);
    add(0, I_OP, 0, 0, 1,  2, 5'b00000, 0, 0, 2, 2, 2, 0, 7);
    add(0, I_OP, 0, 0, 1,  4, 5'b00001, 0, 0, 0, 0, 0, 0, 7);

    drive(1, R_OP, 0, 0, 1);
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].rdy);
      #2;
      chk($sformatf("vec%0d ctl", i), 64'(ctl_act()),
          64'({vecs[i].st, vecs[i].stb, vecs[i].iod, vecs[i].m2r, vecs[i].a, vecs[i].b,
               vecs[i].aop, vecs[i].pcs, vecs[i].st == 3'd5, 2'b00}));
      chk($sformatf("vec%0d instret", i), instret, vecs[i].ins);
      tick();
    end
    chk("after_table state", 64'(state), 64'd0);
    chk("after_table instret", instret, 64'd8);

    // Illegal opcode halts after DECODE and stays halted
    drive(0, 'h7F, 0, 0, 1);
    tick();
    chk("ill decode state", 64'(state), 64'd1);
    tick();
    chk("ill halt", 64'({state, halted, illegal, mem_timeout}), 64'({3'd5, 1'b1, 1'b1, 1'b0}));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("halt_hold%0d", i),
          64'({state, halted, illegal, pc_write, ir_write, mem_read, mem_write, reg_write}),
          64'({3'd5, 1'b1, 1'b1, 5'b00000}));
    end
    chk("halt instret", instret, 64'd8);

    // Reset clears halt, sticky flag and counter
    drive(1, R_OP, 0, 0, 1);
    tick();
    drive(0, EC, 0, 0, 1);
    #2;
    chk("rst clears", 64'({state, illegal, halted}), 64'({3'd0, 1'b0, 1'b0}));
    chk("rst instret", instret, 64'd0);

    // ECALL halts without illegal
    tick();
    tick();
    chk("ecall halt", 64'({state, halted, illegal}), 64'({3'd5, 1'b1, 1'b0}));

    // Fetch timeout after exactly four wait cycles
    drive(1, R_OP, 0, 0, 0);
    tick();
    drive(0, R_OP, 0, 0, 0);
    repeat (3) tick();
    chk("to 3 waits", 64'({state, mem_timeout}), 64'({3'd0, 1'b0}));
    tick();
    chk("to halt", 64'({state, halted, mem_timeout, illegal}), 64'({3'd5, 1'b1, 1'b1, 1'b0}));

    // Ready arriving on the fourth wait cycle completes instead of timing out
    drive(1, R_OP, 0, 0, 0);
    tick();
    drive(0, R_OP, 0, 0, 0);
    repeat (3) tick();
    drive(0, BR, 2, 0, 1);
    #2;
    chk("race ir_write", 64'({ir_write, pc_write}), 64'({1'b1, 1'b1}));
    tick();
    chk("race decode", 64'({state, mem_timeout}), 64'({3'd1, 1'b0}));

    // Unsupported branch funct3 is illegal
    tick();
    chk("bad f3", 64'({state, illegal}), 64'({3'd5, 1'b1}));

    // Reset while a store waits in MEM: strobe drops, nothing retires
    drive(1, ST, 2, 0, 1);
    tick();
    drive(0, ST, 2, 0, 1);
    repeat (3) tick();
    drive(0, ST, 2, 0, 0);
    #2;
    chk("st wait", 64'({state, mem_write, i_or_d}), 64'({3'd3, 1'b1, 1'b1}));
    tick();
    drive(1, ST, 2, 0, 1);
    #2;
    chk("st rst strobe", 64'({state, mem_write, mem_read, pc_write}), 64'({3'd3, 3'b000}));
    tick();
    drive(0, ST, 2, 0, 0);
    #2;
    chk("st rst fetch", 64'({state, mem_write, mem_read}), 64'({3'd0, 1'b0, 1'b1}));
    chk("st rst instret", instret, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
